// File: rtl/picorv_mmio_bridge.sv
// picorv32 native-bus bridge: byte-writable word RAM, UART register block with
// TX/RX byte FIFOs, and an error responder for unmapped or illegal accesses.
module picorv_mmio_bridge #(
  parameter int unsigned RamWords = 256,
  parameter logic [31:0] UartBase = 32'h1000_0000,
  parameter int unsigned TxDepth  = 16,
  parameter int unsigned RxDepth  = 16,
  parameter logic [31:0] ErrData  = 32'hDEAD_BEEF
) (
  input  logic        clk_i,
  input  logic        reset_ni,
  input  logic        mem_valid_i,
  input  logic        mem_instr_i,
  input  logic [31:0] mem_addr_i,
  input  logic [31:0] mem_wdata_i,
  input  logic [3:0]  mem_wstrb_i,
  output logic        mem_ready_o,
  output logic [31:0] mem_rdata_o,
  output logic [7:0]  tx_data_o,
  output logic        tx_valid_o,
  input  logic        tx_ready_i,
  input  logic [7:0]  rx_data_i,
  input  logic        rx_valid_i,
  output logic        bus_err_o
);

  localparam int unsigned RamAw = $clog2(RamWords);
  localparam int unsigned TxAw  = $clog2(TxDepth);
  localparam int unsigned RxAw  = $clog2(RxDepth);
  localparam int unsigned TxCw  = TxAw + 1;
  localparam int unsigned RxCw  = RxAw + 1;
  localparam logic [31:0]     RamBytes  = 32'(RamWords * 4);
  localparam logic [TxCw-1:0] TxFullCnt = TxCw'(TxDepth);
  localparam logic [RxCw-1:0] RxFullCnt = RxCw'(RxDepth);

  localparam logic [1:0] StIdle   = 2'd0;
  localparam logic [1:0] StTxWait = 2'd1;
  localparam logic [1:0] StResp   = 2'd2;

  logic [1:0]  state_q;
  logic [31:0] rdata_q;
  logic [31:0] ram_rd_q;
  logic        ram_resp_q;
  logic        bus_err_q;
  logic        overrun_q;
  logic [7:0]  tx_byte_q;

  logic [31:0] ram_mem [RamWords];
  logic [7:0]  tx_mem [TxDepth];
  logic [7:0]  rx_mem [RxDepth];
  logic [TxAw-1:0] tx_wp_q, tx_rp_q;
  logic [RxAw-1:0] rx_wp_q, rx_rp_q;
  logic [TxCw-1:0] tx_cnt_q;
  logic [RxCw-1:0] rx_cnt_q;

  logic            accept, ram_hit, uart_sel, illegal, is_wr;
  logic [1:0]      reg_off;
  logic [RamAw-1:0] ram_idx;
  logic            tx_full, tx_empty, tx_pop, tx_room;
  logic            rx_full, rx_empty, rx_push, ovr_set;
  logic [4:0]      status;
  logic            tx_push, rx_pop, ovr_clr, tx_stall;
  logic [7:0]      tx_push_data;
  logic [31:0]     rd_next;

  assign accept  = (state_q == StIdle) && mem_valid_i;
  assign ram_hit = mem_addr_i < RamBytes;
  // Fetches may only come from RAM; a fetch that lands on the UART is illegal.
  assign uart_sel = !ram_hit && (mem_addr_i[31:4] == UartBase[31:4]) && !mem_instr_i;
  assign illegal  = !ram_hit && !uart_sel;
  assign is_wr    = |mem_wstrb_i;
  assign reg_off  = mem_addr_i[3:2];
  assign ram_idx  = mem_addr_i[RamAw+1:2];

  assign tx_full  = tx_cnt_q == TxFullCnt;
  assign tx_empty = tx_cnt_q == '0;
  assign tx_pop   = !tx_empty && tx_ready_i;
  assign tx_room  = !tx_full || tx_pop;
  assign rx_full  = rx_cnt_q == RxFullCnt;
  assign rx_empty = rx_cnt_q == '0;
  // A same-cycle RXDATA pop frees a slot for the incoming byte.
  assign rx_push  = rx_valid_i && (!rx_full || rx_pop);
  assign ovr_set  = rx_valid_i && rx_full && !rx_pop;
  assign status   = {overrun_q, rx_full, rx_empty, tx_empty, tx_full};

  always_comb begin
    tx_push      = 1'b0;
    tx_push_data = tx_byte_q;
    rx_pop       = 1'b0;
    ovr_clr      = 1'b0;
    tx_stall     = 1'b0;
    rd_next      = '0;
    if (illegal) begin
      rd_next = ErrData;
    end else if (uart_sel && !is_wr) begin
      case (reg_off)
        2'd1:    rd_next = rx_empty ? 32'hFFFF_FFFF : {24'b0, rx_mem[rx_rp_q]};
        2'd2:    rd_next = {27'b0, status};
        default: rd_next = '0;
      endcase
    end
    if (accept && uart_sel) begin
      case (reg_off)
        2'd0: begin
          if (is_wr && mem_wstrb_i[0]) begin
            if (tx_room) begin
              tx_push      = 1'b1;
              tx_push_data = mem_wdata_i[7:0];
            end else begin
              tx_stall = 1'b1;
            end
          end
        end
        2'd1:    rx_pop  = !is_wr && !rx_empty;
        2'd2:    ovr_clr = is_wr && mem_wdata_i[4];
        default: ;
      endcase
    end
    if (state_q == StTxWait && tx_room) begin
      tx_push = 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      state_q    <= StIdle;
      rdata_q    <= '0;
      ram_resp_q <= 1'b0;
      bus_err_q  <= 1'b0;
      overrun_q  <= 1'b0;
      tx_wp_q    <= '0;
      tx_rp_q    <= '0;
      tx_cnt_q   <= '0;
      rx_wp_q    <= '0;
      rx_rp_q    <= '0;
      rx_cnt_q   <= '0;
    end else begin
      case (state_q)
        StIdle: begin
          if (mem_valid_i) begin
            state_q    <= tx_stall ? StTxWait : StResp;
            rdata_q    <= rd_next;
            ram_resp_q <= ram_hit && !is_wr;
            if (illegal) bus_err_q <= 1'b1;
          end
        end
        StTxWait: if (tx_room) state_q <= StResp;
        StResp:   state_q <= StIdle;
        default:  state_q <= StIdle;
      endcase

      overrun_q <= (overrun_q && !ovr_clr) || ovr_set;

      if (tx_push) tx_wp_q <= tx_wp_q + TxAw'(1);
      if (tx_pop)  tx_rp_q <= tx_rp_q + TxAw'(1);
      case ({tx_push, tx_pop})
        2'b10:   tx_cnt_q <= tx_cnt_q + TxCw'(1);
        2'b01:   tx_cnt_q <= tx_cnt_q - TxCw'(1);
        default: ;
      endcase

      if (rx_push) rx_wp_q <= rx_wp_q + RxAw'(1);
      if (rx_pop)  rx_rp_q <= rx_rp_q + RxAw'(1);
      case ({rx_push, rx_pop})
        2'b10:   rx_cnt_q <= rx_cnt_q + RxCw'(1);
        2'b01:   rx_cnt_q <= rx_cnt_q - RxCw'(1);
        default: ;
      endcase
    end
  end

  // Storage arrays and captured operands carry no reset.
  always_ff @(posedge clk_i) begin
    if (accept && ram_hit) begin
      if (is_wr) begin
        for (int b = 0; b < 4; b++) begin
          if (mem_wstrb_i[b]) ram_mem[ram_idx][8*b +: 8] <= mem_wdata_i[8*b +: 8];
        end
      end else begin
        ram_rd_q <= ram_mem[ram_idx];
      end
    end
    if (accept)  tx_byte_q <= mem_wdata_i[7:0];
    if (tx_push) tx_mem[tx_wp_q] <= tx_push_data;
    if (rx_push) rx_mem[rx_wp_q] <= rx_data_i;
  end

  assign mem_ready_o = state_q == StResp;
  assign mem_rdata_o = ram_resp_q ? ram_rd_q : rdata_q;
  assign tx_valid_o  = !tx_empty;
  assign tx_data_o   = tx_mem[tx_rp_q];
  assign bus_err_o   = bus_err_q;

endmodule

// File: tb/tb_picorv_mmio_bridge.sv
// Directed plus randomized bench for picorv_mmio_bridge, checked against a
// queue/array model of the RAM, FIFOs, overrun flag and bus-error flag.
module tb_picorv_mmio_bridge;
  localparam int          TXD = 16;
  localparam int          RXD = 16;
  localparam logic [31:0] UB  = 32'h1000_0000;
  localparam logic [31:0] ERR = 32'hDEAD_BEEF;

  logic        clk_i = 1'b0;
  logic        reset_ni = 1'b0;
  logic        mem_valid_i = 1'b0;
  logic        mem_instr_i = 1'b0;
  logic [31:0] mem_addr_i = '0;
  logic [31:0] mem_wdata_i = '0;
  logic [3:0]  mem_wstrb_i = '0;
  logic        mem_ready_o;
  logic [31:0] mem_rdata_o;
  logic [7:0]  tx_data_o;
  logic        tx_valid_o;
  logic        tx_ready_i = 1'b0;
  logic [7:0]  rx_data_i = '0;
  logic        rx_valid_i = 1'b0;
  logic        bus_err_o;

  picorv_mmio_bridge #(
    .RamWords(256), .UartBase(UB), .TxDepth(TXD), .RxDepth(RXD), .ErrData(ERR)
  ) dut (
    .clk_i(clk_i), .reset_ni(reset_ni), .mem_valid_i(mem_valid_i),
    .mem_instr_i(mem_instr_i), .mem_addr_i(mem_addr_i), .mem_wdata_i(mem_wdata_i),
    .mem_wstrb_i(mem_wstrb_i), .mem_ready_o(mem_ready_o), .mem_rdata_o(mem_rdata_o),
    .tx_data_o(tx_data_o), .tx_valid_o(tx_valid_o), .tx_ready_i(tx_ready_i),
    .rx_data_i(rx_data_i), .rx_valid_i(rx_valid_i), .bus_err_o(bus_err_o)
  );

  always #5 clk_i = ~clk_i;

  int n_checks = 0;
  int n_pass   = 0;

  logic [31:0] mram [16];
  logic [7:0]  txq [$];
  logic [7:0]  rxq [$];
  logic        m_ovr = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) begin
      n_pass++;
    end else begin
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] mstat();
    return {27'b0, m_ovr, rxq.size() == RXD, rxq.size() == 0,
            txq.size() == 0, txq.size() == TXD};
  endfunction

  task automatic m_rx_read(output logic [31:0] e);
    if (rxq.size() == 0) e = 32'hFFFF_FFFF;
    else e = {24'b0, rxq.pop_front()};
  endtask

  // One bus transaction; checks 1-cycle latency and a single-cycle ready pulse.
  task automatic bus(input logic [31:0] a, input logic [31:0] wd, input logic [3:0] ws,
                     input logic ins, input logic rxv, input logic [7:0] rxd,
                     output logic [31:0] rd);
    int cyc;
    bit got;
    @(negedge clk_i);
    mem_valid_i = 1'b1; mem_addr_i = a; mem_wdata_i = wd;
    mem_wstrb_i = ws;   mem_instr_i = ins;
    rx_valid_i = rxv;   rx_data_i = rxd;
    cyc = 0; got = 0; rd = 'x;
    while (!got && cyc < 50) begin
      @(posedge clk_i); #1;
      cyc++;
      rx_valid_i = 1'b0;
      if (mem_ready_o) begin
        got = 1;
        rd = mem_rdata_o;
      end
    end
    mem_valid_i = 1'b0; mem_instr_i = 1'b0; mem_wstrb_i = '0;
    check("latency", cyc, 1);
    @(posedge clk_i); #1;
    check("ready_one_cycle", mem_ready_o, 1'b0);
  endtask

  task automatic rx_inject(input logic [7:0] b);
    @(negedge clk_i);
    rx_valid_i = 1'b1; rx_data_i = b;
    @(posedge clk_i); #1;
    rx_valid_i = 1'b0;
    if (rxq.size() < RXD) rxq.push_back(b);
    else m_ovr = 1'b1;
  endtask

  task automatic tx_pulse();
    @(negedge clk_i);
    check("tx_valid", tx_valid_o, txq.size() != 0);
    if (txq.size() != 0) check("tx_data", tx_data_o, txq[0]);
    tx_ready_i = 1'b1;
    @(posedge clk_i); #1;
    tx_ready_i = 1'b0;
    if (txq.size() != 0) void'(txq.pop_front());
  endtask

  initial begin
    logic [31:0] rd, wd, e;
    logic [3:0]  ws;
    int          idx;
    bit          saw_ready;

    // Reset state
    repeat (3) @(posedge clk_i);
    #1;
    check("rst_ready", mem_ready_o, 1'b0);
    check("rst_rdata", mem_rdata_o, 32'h0);
    check("rst_tx_valid", tx_valid_o, 1'b0);
    check("rst_bus_err", bus_err_o, 1'b0);
    @(negedge clk_i);
    reset_ni = 1'b1;
    bus(UB + 8, 0, 4'h0, 0, 0, 0, rd);
    check("status_after_reset", rd, 32'h06);

    // RAM: fill model words, then directed byte-lane merge, then random traffic
    for (int i = 0; i < 16; i++) begin
      wd = $urandom;
      bus(i * 4, wd, 4'hF, 0, 0, 0, rd);
      mram[i] = wd;
    end
    bus(32'h10, 32'h1234_5678, 4'b0011, 0, 0, 0, rd);
    check("ram_wr_rdata", rd, 32'h0);
    bus(32'h10, 32'hAABB_CCDD, 4'b1100, 0, 0, 0, rd);
    bus(32'h10, 0, 4'h0, 0, 0, 0, rd);
    check("ram_merge", rd, {16'hAABB, mram[4][15:0] & 16'h0 | 16'h5678});
    mram[4] = 32'hAABB_5678;
    repeat (40) begin
      idx = $urandom_range(0, 15);
      ws  = 4'($urandom_range(0, 15));
      wd  = $urandom;
      bus(32'(idx * 4 + $urandom_range(0, 3)), wd, ws, 0, 0, 0, rd);
      if (ws == 0) begin
        check("ram_rand_rd", rd, mram[idx]);
      end else begin
        check("ram_rand_wr_rdata", rd, 32'h0);
        for (int b = 0; b < 4; b++) if (ws[b]) mram[idx][8*b +: 8] = wd[8*b +: 8];
      end
    end
    idx = $urandom_range(0, 15);
    bus(32'(idx * 4), 0, 4'h0, 1, 0, 0, rd);
    check("ram_fetch", rd, mram[idx]);
    bus(32'h3FC, 32'hC0FF_EE11, 4'hF, 0, 0, 0, rd);
    bus(32'h3FC, 0, 4'h0, 0, 0, 0, rd);
    check("ram_top_word", rd, 32'hC0FF_EE11);

    // TX: 16 writes fill the FIFO, the 17th stalls until one pop
    for (int i = 0; i < 16; i++) begin
      bus(UB, {24'($urandom), 8'(i)}, 4'b0001, 0, 0, 0, rd);
      txq.push_back(8'(i));
    end
    bus(UB + 8, 0, 4'h0, 0, 0, 0, rd);
    check("status_tx_full", rd, 32'h05);
    @(negedge clk_i);
    mem_valid_i = 1'b1; mem_addr_i = UB; mem_wdata_i = 32'h0000_0010; mem_wstrb_i = 4'b0001;
    saw_ready = 0;
    repeat (4) begin
      @(posedge clk_i); #1;
      if (mem_ready_o) saw_ready = 1;
    end
    check("txwait_stall", saw_ready, 1'b0);
    check("txwait_head", tx_data_o, txq[0]);
    @(negedge clk_i);
    tx_ready_i = 1'b1;
    @(posedge clk_i); #1;
    tx_ready_i = 1'b0;
    void'(txq.pop_front());
    txq.push_back(8'h10);
    check("txwait_done", mem_ready_o, 1'b1);
    check("txwait_rdata", mem_rdata_o, 32'h0);
    mem_valid_i = 1'b0; mem_wstrb_i = '0;
    @(posedge clk_i); #1;
    check("txwait_ready_drop", mem_ready_o, 1'b0);
    while (txq.size() != 0) tx_pulse();
    check("tx_drained", tx_valid_o, 1'b0);

    // RX overrun, overrun clear, drain, empty read
    for (int i = 0; i < 17; i++) rx_inject(8'($urandom));
    bus(UB + 8, 0, 4'h0, 0, 0, 0, rd);
    check("status_overrun", rd, 32'h1A);
    bus(UB + 8, 32'h10, 4'hF, 0, 0, 0, rd);
    m_ovr = 1'b0;
    bus(UB + 8, 0, 4'h0, 0, 0, 0, rd);
    check("status_ovr_clr", rd, 32'h0A);
    for (int i = 0; i < 17; i++) begin
      bus(UB + 4, 0, 4'h0, 0, 0, 0, rd);
      m_rx_read(e);
      check("rx_drain", rd, e);
    end

    // RX full with a coinciding pop: push succeeds, no overrun
    for (int i = 0; i < 16; i++) rx_inject(8'($urandom));
    bus(UB + 4, 0, 4'h0, 0, 1, 8'hC3, rd);
    m_rx_read(e);
    rxq.push_back(8'hC3);
    check("rx_simul_data", rd, e);
    bus(UB + 8, 0, 4'h0, 0, 0, 0, rd);
    check("rx_simul_status", rd, mstat());
    for (int i = 0; i < 17; i++) begin
      bus(UB + 4, 0, 4'h0, 0, 0, 0, rd);
      m_rx_read(e);
      check("rx_simul_drain", rd, e);
    end

    // Random UART register traffic
    repeat (80) begin
      case ($urandom_range(0, 6))
        0: rx_inject(8'($urandom));
        1: begin
          bus(UB + 4, 0, 4'h0, 0, 0, 0, rd);
          m_rx_read(e);
          check("rnd_rxdata", rd, e);
        end
        2: begin
          bus(UB + 8, 0, 4'h0, 0, 0, 0, rd);
          check("rnd_status", rd, mstat());
        end
        3: begin
          if (txq.size() < TXD) begin
            ws = 4'($urandom_range(1, 15));
            wd = $urandom;
            bus(UB + 32'($urandom_range(0, 3)), wd, ws, 0, 0, 0, rd);
            check("rnd_tx_wr_rdata", rd, 32'h0);
            if (ws[0]) txq.push_back(wd[7:0]);
          end else begin
            tx_pulse();
          end
        end
        4: tx_pulse();
        5: begin
          wd = $urandom;
          bus(UB + 8, wd, 4'hF, 0, 0, 0, rd);
          if (wd[4]) m_ovr = 1'b0;
        end
        default: begin
          bus(($urandom_range(0, 1) != 0) ? UB + 12 : UB, 0, 4'h0, 0, 0, 0, rd);
          check("rnd_zero_reg", rd, 32'h0);
        end
      endcase
    end
    while (txq.size() != 0) tx_pulse();

    // Unmapped and illegal accesses
    check("bus_err_pre", bus_err_o, 1'b0);
    bus(32'h2000_0000, 0, 4'h0, 0, 0, 0, rd);
    check("unmapped_rd", rd, ERR);
    check("bus_err_set", bus_err_o, 1'b1);
    bus(32'h2000_0000, 32'h1111_2222, 4'hF, 0, 0, 0, rd);
    check("unmapped_wr", rd, ERR);
    bus(32'h0, 0, 4'h0, 0, 0, 0, rd);
    check("ram_untouched", rd, mram[0]);
    bus(32'h400, 0, 4'h0, 0, 0, 0, rd);
    check("ram_end_unmapped", rd, ERR);
    bus(UB + 16, 0, 4'h0, 0, 0, 0, rd);
    check("uart_end_unmapped", rd, ERR);
    while (rxq.size() != 0) begin
      bus(UB + 4, 0, 4'h0, 0, 0, 0, rd);
      m_rx_read(e);
    end
    rx_inject(8'h5A);
    bus(UB + 4, 0, 4'h0, 1, 0, 0, rd);
    check("fetch_rxdata", rd, ERR);
    bus(UB, 0, 4'h0, 1, 0, 0, rd);
    check("fetch_uart", rd, ERR);
    bus(UB + 4, 0, 4'h0, 0, 0, 0, rd);
    m_rx_read(e);
    check("fetch_no_pop", rd, e);
    check("bus_err_sticky", bus_err_o, 1'b1);

    // Reset while stalled in TXWAIT
    for (int i = 0; i < 16; i++) begin
      bus(UB, 32'(i + 8'h40), 4'b0001, 0, 0, 0, rd);
      txq.push_back(8'(i + 8'h40));
    end
    rx_inject(8'h77);
    @(negedge clk_i);
    mem_valid_i = 1'b1; mem_addr_i = UB; mem_wdata_i = 32'h99; mem_wstrb_i = 4'b0001;
    repeat (3) @(posedge clk_i);
    #2;
    reset_ni = 1'b0;
    #1;
    check("rst_async_ready", mem_ready_o, 1'b0);
    check("rst_async_tx_valid", tx_valid_o, 1'b0);
    mem_valid_i = 1'b0; mem_wstrb_i = '0;
    txq.delete(); rxq.delete(); m_ovr = 1'b0;
    repeat (2) @(posedge clk_i);
    @(negedge clk_i);
    reset_ni = 1'b1;
    check("rst_bus_err_clr", bus_err_o, 1'b0);
    bus(UB + 8, 0, 4'h0, 0, 0, 0, rd);
    check("rst_status", rd, mstat());

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
